alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for the shared registered 32-bit ALU.
- Accepts {ctl, A, B} operation requests over valid/ready handshakes and drives them into the ALU.
- Waits for the ALU's one-cycle registered result, then returns it to the granted requester over a valid/ready response channel.
- Sits between decode/execute clients (e.g. main execute path and branch compare unit) and the single ALU instance.

Parameters:
WIDTH, 32, operand/result width
CTLW, 4, ALU control code width
CNT_W, 16, width of completed-operation counter

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
req_valid  input  2  per-requester request valid
req_ready  output  2  per-requester request accept (one-hot or zero)
req_ctl0  input  CTLW  requester 0 ALU control code
req_a0  input  WIDTH  requester 0 operand A
req_b0  input  WIDTH  requester 0 operand B
req_ctl1  input  CTLW  requester 1 ALU control code
req_a1  input  WIDTH  requester 1 operand A
req_b1  input  WIDTH  requester 1 operand B
resp_valid  output  2  one-hot response valid, routed to the owning requester
resp_ready  input  2  per-requester response accept
resp_data  output  WIDTH  captured ALU result
resp_zero  output  1  captured ALU zero flag
resp_err  output  1  illegal-op flag (only with optional feature, else 0)
alu_ctl  output  CTLW  to ALU control input
alu_a  output  WIDTH  to ALU operand A
alu_b  output  WIDTH  to ALU operand B
alu_out  input  WIDTH  from ALU result (registered in ALU)
alu_zero  input  1  from ALU zero flag
busy  output  1  high whenever state != IDLE
op_count  output  CNT_W  count of completed responses

Behaviour:
- Reset (clk edge with rst=1): state=IDLE, last_grant=1, owner=0, op regs alu_ctl/alu_a/alu_b=0, resp_data=0, resp_zero=0, resp_err=0, op_count=0. All outputs are 0 during and after reset. rst dominates every other input.
- FSM states: IDLE, EXEC, CAPT, RESP.
- IDLE:
  - Grant: if only one req_valid bit is set, grant that requester. If both are set, grant the requester != last_grant (round-robin).
  - req_ready[g] is driven high combinationally in IDLE for the granted requester only. req_ready is 0 in every other state.
  - On handshake: latch ctl/A/B of requester g into op regs; owner<=g; last_grant<=g; go to EXEC.
- EXEC: op regs drive the ALU; the ALU registers its result at this edge. Go to CAPT.
- CAPT: resp_data<=alu_out, resp_zero<=alu_zero, resp_err<=0. Go to RESP.
- RESP:
  - resp_valid[owner]=1, other bit 0.
  - Hold resp_data/resp_zero/resp_err stable until resp_ready[owner]=1.
  - On that handshake: op_count<=op_count+1 (wraps 2^CNT_W-1 -> 0); go to IDLE.
  - resp_ready of the non-owner is ignored.
- Latency: request accepted at edge T -> resp_valid high from edge T+3. Minimum issue interval is 4 cycles (back-to-back when resp_ready is held high).
- No new request is accepted in RESP. A request handshake in IDLE cannot coincide with a response handshake.
- Op regs hold their last value in IDLE, so the ALU recomputes harmlessly.
- Reset mid-operation (any state): operation dropped, no response issued, op_count unchanged from reset value 0.
- Requester inputs need only be stable in the handshake cycle.

Optional Feature:
Macro ALU_ARB_OPCHK_EN.
- Defined:
  - At accept, check ctl against the legal set {0000,0001,0010,0110,0101,1100,0111,1000,1010,0100}.
  - Illegal code: skip EXEC/CAPT, go IDLE->RESP directly with resp_data=0, resp_zero=0, resp_err=1; op regs are not updated. Latency is 1 cycle.
  - Illegal ops still count in op_count.
- Undefined: all codes go to the ALU unchanged; resp_err is tied 0.

Test Plan:
- Reset, then req_valid=01, ctl=0010, A=5, B=7 -> req_ready=01 same cycle; resp_valid=01 three edges after accept; resp_data=12, resp_zero=0; op_count=1 after resp handshake.
- Requester 1: ctl=0110, A=9, B=9 -> resp_valid=10, resp_data=0, resp_zero=1.
- Both valid continuously after reset, resp_ready=11 -> grants alternate 0,1,0,1; each response routed to the matching resp_valid bit; issue interval is 4 cycles.
- Response backpressure: resp_ready=00 for 5 cycles in RESP -> resp_valid and resp_data held stable; req_ready=00 throughout; completes when resp_ready[owner] rises.
- Assert rst in EXEC -> next cycle state IDLE, resp_valid=00, busy=0, op_count=0; a subsequent request completes normally.
- With ALU_ARB_OPCHK_EN, ctl=1111 -> resp_valid after 1 edge, resp_err=1, resp_data=0; alu_ctl unchanged. Without the macro -> normal 3-cycle path, resp_err=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for the shared registered ALU (optional opcode check: ALU_ARB_OPCHK_EN)
module alu_arbiter #(
   parameter int WIDTH = 32,
   parameter int CTLW  = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [CTLW-1:0]  req_ctl0,
   input  logic [WIDTH-1:0] req_a0,
   input  logic [WIDTH-1:0] req_b0,
   input  logic [CTLW-1:0]  req_ctl1,
   input  logic [WIDTH-1:0] req_a1,
   input  logic [WIDTH-1:0] req_b1,
   output logic [1:0]       resp_valid,
   input  logic [1:0]       resp_ready,
   output logic [WIDTH-1:0] resp_data,
   output logic             resp_zero,
   output logic             resp_err,
   output logic [CTLW-1:0]  alu_ctl,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_zero,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);
   typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;
   state_t state_q, state_d;
   logic last_grant_q, owner_q, gnt, acc, resp_hs, illegal;
   logic [CTLW-1:0] ctl_q, sel_ctl;
   logic [WIDTH-1:0] a_q, b_q, data_q, sel_a, sel_b;
   logic zero_q;
   logic [CNT_W-1:0] cnt_q;
`ifdef ALU_ARB_OPCHK_EN
   logic err_q;
   assign resp_err = err_q;
`else
   assign resp_err = 1'b0;
`endif
   assign alu_ctl = ctl_q;
   assign alu_a = a_q;
   assign alu_b = b_q;
   assign resp_data = data_q;
   assign resp_zero = zero_q;
   assign op_count = cnt_q;
   // round-robin grant, operand select and handshake decode; reset masks both handshakes
   always_comb begin
      gnt = (&req_valid) ? ~last_grant_q : req_valid[1];
      acc = ~rst && state_q == IDLE && |req_valid;
      resp_hs = ~rst && state_q == RESP && resp_ready[owner_q];
      sel_ctl = gnt ? req_ctl1 : req_ctl0;
      sel_a = gnt ? req_a1 : req_a0;
      sel_b = gnt ? req_b1 : req_b0;
`ifdef ALU_ARB_OPCHK_EN
      illegal = !(sel_ctl inside {CTLW'(0), CTLW'(1), CTLW'(2), CTLW'(6), CTLW'(5),
                                  CTLW'(12), CTLW'(7), CTLW'(8), CTLW'(10), CTLW'(4)});
`else
      illegal = 1'b0;
`endif
   end
   // state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else state_q <= state_d;
   end
   // next state: illegal codes bypass the ALU and respond immediately
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: state_d = acc ? (illegal ? RESP : EXEC) : IDLE;
         EXEC: state_d = CAPT;
         CAPT: state_d = RESP;
         RESP: state_d = resp_hs ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
   end
   // handshake outputs, forced low while reset is asserted
   always_comb begin
      req_ready = acc ? (gnt ? 2'b10 : 2'b01) : 2'b00;
      resp_valid = (~rst && state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
      busy = ~rst && state_q != IDLE;
   end
   // operand latch, result capture and completion counter
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= 1'b1;
         owner_q <= 1'b0;
         ctl_q <= '0;
         a_q <= '0;
         b_q <= '0;
         data_q <= '0;
         zero_q <= 1'b0;
         cnt_q <= '0;
`ifdef ALU_ARB_OPCHK_EN
         err_q <= 1'b0;
`endif
      end else begin
         if (acc) begin
            last_grant_q <= gnt;
            owner_q <= gnt;
         end
         if (acc && !illegal) begin
            ctl_q <= sel_ctl;
            a_q <= sel_a;
            b_q <= sel_b;
         end
         if (state_q == CAPT) begin
            data_q <= alu_out;
            zero_q <= alu_zero;
         end
`ifdef ALU_ARB_OPCHK_EN
         if (state_q == CAPT) err_q <= 1'b0;
         if (acc && illegal) begin
            data_q <= '0;
            zero_q <= 1'b0;
            err_q <= 1'b1;
         end
`endif
         if (resp_hs) cnt_q <= cnt_q + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a registered ALU model
module tb_alu_arbiter;
   logic clk = 0, rst = 1;
   logic [1:0] req_valid = 0, req_ready, resp_valid, resp_ready = 0;
   logic [3:0] req_ctl0 = 0, req_ctl1 = 0, alu_ctl;
   logic [31:0] req_a0 = 0, req_b0 = 0, req_a1 = 0, req_b1 = 0;
   logic [31:0] resp_data, alu_a, alu_b, alu_out = 0;
   logic resp_zero, resp_err, busy, alu_zero = 0;
   logic [15:0] op_count;
   int checks = 0, failures = 0;
   typedef struct {logic [1:0] oh; logic [31:0] data; logic zero; logic err;} exp_t;
   exp_t sb[$];
`ifdef ALU_ARB_OPCHK_EN
   localparam int LAT = 1;
   localparam bit EN = 1;
`else
   localparam int LAT = 3;
   localparam bit EN = 0;
`endif

   alu_arbiter dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_ctl0(req_ctl0), .req_a0(req_a0), .req_b0(req_b0),
      .req_ctl1(req_ctl1), .req_a1(req_a1), .req_b1(req_b1),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_zero(resp_zero), .resp_err(resp_err), .alu_ctl(alu_ctl), .alu_a(alu_a),
      .alu_b(alu_b), .alu_out(alu_out), .alu_zero(alu_zero), .busy(busy), .op_count(op_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_f(logic [3:0] c, logic [31:0] a, logic [31:0] b);
      case (c)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a + b;
         4'b0110: return a - b;
         4'b0111: return {31'b0, $signed(a) < $signed(b)};
         4'b1100: return ~(a | b);
         default: return a ^ b;
      endcase
   endfunction

   function automatic exp_t mk(logic [1:0] oh, logic [3:0] c, logic [31:0] a, logic [31:0] b);
      exp_t e;
      e.oh = oh;
      e.data = alu_f(c, a, b);
      e.zero = (e.data == 0);
      e.err = 1'b0;
      return e;
   endfunction

   always @(posedge clk) begin
      alu_out <= alu_f(alu_ctl, alu_a, alu_b);
      alu_zero <= (alu_f(alu_ctl, alu_a, alu_b) == 0);
   end

   always @(negedge clk) begin
      if (!rst && (resp_valid & resp_ready) != 2'b00) begin
         exp_t e;
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_empty unexpected response valid=%b data=%h", resp_valid, resp_data);
         end else begin
            e = sb.pop_front();
            if (resp_valid !== e.oh || resp_data !== e.data || resp_zero !== e.zero || resp_err !== e.err) begin
               failures++;
               $display("FAIL resp got v=%b d=%h z=%b e=%b exp v=%b d=%h z=%b e=%b",
                        resp_valid, resp_data, resp_zero, resp_err, e.oh, e.data, e.zero, e.err);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1;
      req_valid = 2'b11;
      resp_ready = 2'b11;
      tick();
      tick();
      @(negedge clk);
      checks++;
      if ({req_ready, resp_valid, busy} !== 5'b0) begin
         failures++;
         $display("FAIL reset_hs got rdy=%b v=%b busy=%b exp 0", req_ready, resp_valid, busy);
      end
      checks++;
      if ({op_count, resp_data, resp_zero, resp_err, alu_ctl, alu_a, alu_b} !== '0) begin
         failures++;
         $display("FAIL reset_regs got cnt=%0d d=%h ctl=%h a=%h b=%h exp 0", op_count, resp_data, alu_ctl, alu_a, alu_b);
      end
      tick();
      rst = 0;
      req_valid = 0;
      resp_ready = 0;
      @(negedge clk);
   endtask

   task automatic test_single0();
      tick();
      req_valid = 2'b01;
      req_ctl0 = 4'b0010;
      req_a0 = 5;
      req_b0 = 7;
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b01) begin
         failures++;
         $display("FAIL single0_rdy got %b exp 01", req_ready);
      end
      sb.push_back(mk(2'b01, 4'b0010, 5, 7));
      for (int n = 1; n <= 3; n++) begin
         tick();
         if (n == 1) begin
            req_valid = 0;
            req_a0 = $urandom;
         end
         @(negedge clk);
         checks++;
         if (resp_valid !== (n == 3 ? 2'b01 : 2'b00) || busy !== 1'b1) begin
            failures++;
            $display("FAIL single0_lat n=%0d got v=%b busy=%b", n, resp_valid, busy);
         end
         if (n == 1) begin
            checks++;
            if (alu_a !== 32'd5) begin
               failures++;
               $display("FAIL single0_alu_a got %h exp 5", alu_a);
            end
         end
      end
      tick();
      resp_ready = 2'b01;
      @(negedge clk);
      tick();
      resp_ready = 0;
      @(negedge clk);
      checks++;
      if (op_count !== 16'd1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL single0_cnt got cnt=%0d busy=%b exp 1 0", op_count, busy);
      end
   endtask

   task automatic test_req1();
      tick();
      req_valid = 2'b10;
      req_ctl1 = 4'b0110;
      req_a1 = 9;
      req_b1 = 9;
      resp_ready = 2'b11;
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b10) begin
         failures++;
         $display("FAIL req1_rdy got %b exp 10", req_ready);
      end
      sb.push_back(mk(2'b10, 4'b0110, 9, 9));
      for (int n = 1; n <= 3; n++) begin
         tick();
         if (n == 1) req_valid = 0;
         @(negedge clk);
         checks++;
         if (resp_valid !== (n == 3 ? 2'b10 : 2'b00)) begin
            failures++;
            $display("FAIL req1_lat n=%0d got %b", n, resp_valid);
         end
      end
      tick();
      resp_ready = 0;
      @(negedge clk);
      checks++;
      if (op_count !== 16'd2 || busy !== 1'b0) begin
         failures++;
         $display("FAIL req1_cnt got cnt=%0d busy=%b exp 2 0", op_count, busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] er;
      tick();
      rst = 1;
      tick();
      rst = 0;
      req_ctl0 = 4'b0010;
      req_b0 = 23;
      req_ctl1 = 4'b0110;
      req_b1 = 8;
      for (int k = 0; k < 16; k++) begin
         if (k > 0) tick();
         if (k == 0) begin
            req_valid = 2'b11;
            resp_ready = 2'b11;
         end
         if (k == 13) req_valid = 0;
         req_a0 = 100 + k;
         req_a1 = 50 + k;
         @(negedge clk);
         er = (k % 4 != 0) ? 2'b00 : (((k / 4) % 2) == 1 ? 2'b10 : 2'b01);
         checks++;
         if (req_ready !== er) begin
            failures++;
            $display("FAIL b2b_rdy k=%0d got %b exp %b", k, req_ready, er);
         end
         if (er == 2'b01) sb.push_back(mk(er, req_ctl0, req_a0, req_b0));
         if (er == 2'b10) sb.push_back(mk(er, req_ctl1, req_a1, req_b1));
      end
      tick();
      resp_ready = 0;
      @(negedge clk);
      checks++;
      if (op_count !== 16'd4 || busy !== 1'b0) begin
         failures++;
         $display("FAIL b2b_cnt got cnt=%0d busy=%b exp 4 0", op_count, busy);
      end
   endtask

   task automatic test_backpressure();
      tick();
      req_valid = 2'b01;
      req_ctl0 = 4'b0000;
      req_a0 = 32'hF0F0;
      req_b0 = 32'hFF00;
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b01) begin
         failures++;
         $display("FAIL bp_rdy got %b exp 01", req_ready);
      end
      sb.push_back(mk(2'b01, 4'b0000, 32'hF0F0, 32'hFF00));
      tick();
      req_valid = 2'b11;
      @(negedge clk);
      tick();
      @(negedge clk);
      for (int h = 0; h <= 5; h++) begin
         tick();
         resp_ready = (h == 5) ? 2'b01 : 2'b10;
         if (h == 5) req_valid = 0;
         @(negedge clk);
         if (h < 5) begin
            checks++;
            if (resp_valid !== 2'b01 || resp_data !== 32'hF000 || req_ready !== 2'b00 || busy !== 1'b1) begin
               failures++;
               $display("FAIL bp_hold h=%0d got v=%b d=%h rdy=%b busy=%b exp 01 f000 00 1",
                        h, resp_valid, resp_data, req_ready, busy);
            end
         end
      end
      tick();
      resp_ready = 0;
      @(negedge clk);
      checks++;
      if (op_count !== 16'd5 || busy !== 1'b0) begin
         failures++;
         $display("FAIL bp_cnt got cnt=%0d busy=%b exp 5 0", op_count, busy);
      end
   endtask

   task automatic test_reset_mid();
      tick();
      req_valid = 2'b10;
      req_ctl1 = 4'b0010;
      req_a1 = 1;
      req_b1 = 2;
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b10) begin
         failures++;
         $display("FAIL rmid_rdy got %b exp 10", req_ready);
      end
      tick();
      req_valid = 0;
      rst = 1;
      @(negedge clk);
      tick();
      rst = 0;
      @(negedge clk);
      checks++;
      if (resp_valid !== 2'b00 || busy !== 1'b0 || op_count !== 16'd0) begin
         failures++;
         $display("FAIL rmid_state got v=%b busy=%b cnt=%0d exp 00 0 0", resp_valid, busy, op_count);
      end
      tick();
      req_valid = 2'b01;
      req_ctl0 = 4'b0111;
      req_a0 = -3;
      req_b0 = 2;
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b01) begin
         failures++;
         $display("FAIL rmid_rdy2 got %b exp 01", req_ready);
      end
      sb.push_back(mk(2'b01, 4'b0111, -3, 2));
      for (int n = 1; n <= 4; n++) begin
         tick();
         if (n == 1) begin
            req_valid = 0;
            resp_ready = 2'b01;
         end
         @(negedge clk);
         if (n == 3) begin
            checks++;
            if (resp_valid !== 2'b01) begin
               failures++;
               $display("FAIL rmid_lat got %b exp 01", resp_valid);
            end
         end
      end
      checks++;
      if (op_count !== 16'd1) begin
         failures++;
         $display("FAIL rmid_cnt got %0d exp 1", op_count);
      end
   endtask

   task automatic test_opchk();
      logic [3:0] prev, ectl;
      exp_t e;
      tick();
      prev = alu_ctl;
      req_valid = 2'b01;
      req_ctl0 = 4'b1111;
      req_a0 = 3;
      req_b0 = 4;
      resp_ready = 2'b01;
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b01) begin
         failures++;
         $display("FAIL opchk_rdy got %b exp 01", req_ready);
      end
      e = mk(2'b01, 4'b1111, 3, 4);
      if (EN) begin
         e.data = 0;
         e.zero = 0;
         e.err = 1;
      end
      ectl = EN ? prev : 4'b1111;
      sb.push_back(e);
      for (int n = 1; n <= LAT; n++) begin
         tick();
         if (n == 1) req_valid = 0;
         @(negedge clk);
         checks++;
         if (resp_valid !== (n == LAT ? 2'b01 : 2'b00)) begin
            failures++;
            $display("FAIL opchk_lat n=%0d got %b", n, resp_valid);
         end
         if (n == 1) begin
            checks++;
            if (alu_ctl !== ectl) begin
               failures++;
               $display("FAIL opchk_ctl got %h exp %h", alu_ctl, ectl);
            end
         end
      end
      tick();
      resp_ready = 0;
      @(negedge clk);
      checks++;
      if (op_count !== 16'd2 || busy !== 1'b0) begin
         failures++;
         $display("FAIL opchk_cnt got cnt=%0d busy=%b exp 2 0", op_count, busy);
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_drain got %0d pending exp 0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_single0();
      test_req1();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_opchk();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
